transmission_checker: RTL

TRANSMISSION_CHECKER -- requirements
Module: transmission_checker

---
 rtl/transmission_checker.sv | 91 +++++++++
 1 files changed

// File: rtl/transmission_checker.sv
// transmission_checker: checks bursts of incrementing 32-bit words and reports per-burst and cumulative error statistics.
module transmission_checker #(
    parameter int WORDS_PER_BURST = 1024,
    parameter int GAP_TIMEOUT     = 16
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] rx_data,
    input  logic        rx_write,
    input  logic        clear,
    output logic        busy,
    output logic        burst_done,
    output logic        burst_ok,
    output logic        timeout,
    output logic [15:0] word_count,
    output logic [15:0] error_count,
    output logic [15:0] first_err_idx
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      r_state;
    logic [31:0] r_expected;
    logic [15:0] r_idle_cnt;
    logic        r_err_flag;
    logic        w_mismatch;
    logic        w_last;
    logic        w_gap;
    assign w_mismatch = r_state == RUN && rx_write && rx_data != r_expected;
    assign w_last     = word_count == 16'(WORDS_PER_BURST - 1);
    assign w_gap      = r_idle_cnt == 16'(GAP_TIMEOUT - 1);
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state       <= IDLE;
            r_expected    <= '0;
            r_idle_cnt    <= '0;
            r_err_flag    <= 1'b0;
            busy          <= 1'b0;
            burst_done    <= 1'b0;
            burst_ok      <= 1'b0;
            timeout       <= 1'b0;
            word_count    <= '0;
            error_count   <= '0;
            first_err_idx <= 16'hFFFF;
        end else begin
            burst_done  <= 1'b0;
            timeout     <= 1'b0;
            error_count <= clear ? 16'h0 :
                           (w_mismatch && error_count != 16'hFFFF) ? error_count + 16'h1 : error_count;
            case (r_state)
                RUN: begin
                    if (rx_write) begin
                        r_expected <= rx_data + 32'h1;
                        word_count <= word_count + 16'h1;
                        r_idle_cnt <= '0;
                        if (w_mismatch) begin
                            r_err_flag <= 1'b1;
                            if (first_err_idx == 16'hFFFF) first_err_idx <= word_count;
                        end
                        if (w_last) begin
                            r_state    <= DONE;
                            busy       <= 1'b0;
                            burst_done <= 1'b1;
                            burst_ok   <= !(r_err_flag || w_mismatch);
                        end
                    end else if (w_gap) begin
                        r_state    <= DONE;
                        busy       <= 1'b0;
                        burst_done <= 1'b1;
                        timeout    <= 1'b1;
                        burst_ok   <= 1'b0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 16'h1;
                    end
                end
                default: begin
                    if (rx_write) begin
                        r_state       <= RUN;
                        busy          <= 1'b1;
                        r_expected    <= rx_data + 32'h1;
                        r_idle_cnt    <= '0;
                        r_err_flag    <= 1'b0;
                        word_count    <= 16'h1;
                        first_err_idx <= 16'hFFFF;
                    end else begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
